// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair sharing two DEPTH-entry banks; join mode lends both banks to one direction.
// Sticky error flags, level thresholds and a mode-change flush.
module pio_fifo_pair #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(2*DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       join_i,
  input  logic             tx_push_i,
  input  logic [WIDTH-1:0] tx_din_i,
  input  logic             tx_pull_i,
  output logic [WIDTH-1:0] tx_dout_o,
  input  logic             rx_push_i,
  input  logic [WIDTH-1:0] rx_din_i,
  input  logic             rx_pull_i,
  output logic [WIDTH-1:0] rx_dout_o,
  output logic             tx_empty_o,
  output logic             tx_full_o,
  output logic             rx_empty_o,
  output logic             rx_full_o,
  output logic [LW-1:0]    tx_level_o,
  output logic [LW-1:0]    rx_level_o,
  input  logic [LW-1:0]    tx_thresh_i,
  input  logic [LW-1:0]    rx_thresh_i,
  output logic             tx_req_o,
  output logic             rx_req_o,
  input  logic [3:0]       flag_clr_i,
  output logic [3:0]       flags_o
);

  localparam int unsigned PW = $clog2(2*DEPTH);
  localparam logic [LW-1:0] CAP_BANK = LW'(DEPTH);
  localparam logic [LW-1:0] CAP_JOIN = LW'(2*DEPTH);

  typedef enum logic [1:0] {
    MODE_SEP     = 2'b00,
    MODE_JOIN_TX = 2'b01,
    MODE_JOIN_RX = 2'b10
  } mode_e;

  logic [WIDTH-1:0] mem_q [2*DEPTH];
  logic [1:0]       join_q, join_d;
  mode_e            mode;
  logic [PW-1:0]    tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [PW-1:0]    rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [LW-1:0]    tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
  logic [3:0]       flags_q, flags_d, flag_set;
  logic [LW-1:0]    tx_cap, rx_cap;
  logic [PW-1:0]    rx_base;
  logic             flush;
  logic             tx_push_ok, tx_pull_ok, rx_push_ok, rx_pull_ok;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [LW-1:0] cap);
    return ({1'b0, p} == cap - LW'(1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mode    = MODE_SEP;
    tx_cap  = CAP_BANK;
    rx_cap  = CAP_BANK;
    rx_base = PW'(DEPTH);
    case (join_q)
      2'b01:   mode = MODE_JOIN_TX;
      2'b10:   mode = MODE_JOIN_RX;
      default: mode = MODE_SEP;
    endcase
    case (mode)
      MODE_JOIN_TX: begin tx_cap = CAP_JOIN; rx_cap = '0; rx_base = '0; end
      MODE_JOIN_RX: begin tx_cap = '0; rx_cap = CAP_JOIN; rx_base = '0; end
      default:      ;
    endcase
  end

  assign flush      = (join_i != join_q);
  assign tx_full_o  = (tx_lvl_q == tx_cap);
  assign tx_empty_o = (tx_lvl_q == '0);
  assign rx_full_o  = (rx_lvl_q == rx_cap);
  assign rx_empty_o = (rx_lvl_q == '0);
  assign tx_level_o = tx_lvl_q;
  assign rx_level_o = rx_lvl_q;
  assign flags_o    = flags_q;
  assign tx_req_o   = (tx_lvl_q < tx_thresh_i);
  assign rx_req_o   = (rx_thresh_i != '0) && (rx_lvl_q >= rx_thresh_i);
  assign tx_dout_o  = mem_q[tx_rd_q];
  assign rx_dout_o  = mem_q[rx_base + rx_rd_q];

  // A zero-capacity FIFO is both full and empty, so its push/pull are rejected by the
  // normal checks; only flag raising needs the explicit capacity guard.
  assign tx_push_ok = tx_push_i && !tx_full_o  && !flush;
  assign tx_pull_ok = tx_pull_i && !tx_empty_o && !flush;
  assign rx_push_ok = rx_push_i && !rx_full_o  && !flush;
  assign rx_pull_ok = rx_pull_i && !rx_empty_o && !flush;

  always_comb begin
    flag_set    = '0;
    flag_set[0] = tx_push_i && tx_full_o  && (tx_cap != '0) && !flush;
    flag_set[1] = tx_pull_i && tx_empty_o && (tx_cap != '0) && !flush;
    flag_set[2] = rx_push_i && rx_full_o  && (rx_cap != '0) && !flush;
    flag_set[3] = rx_pull_i && rx_empty_o && (rx_cap != '0) && !flush;
    flags_d     = (flags_q & ~flag_clr_i) | flag_set;
    join_d      = join_i;
    tx_rd_d     = tx_pull_ok ? adv(tx_rd_q, tx_cap) : tx_rd_q;
    tx_wr_d     = tx_push_ok ? adv(tx_wr_q, tx_cap) : tx_wr_q;
    rx_rd_d     = rx_pull_ok ? adv(rx_rd_q, rx_cap) : rx_rd_q;
    rx_wr_d     = rx_push_ok ? adv(rx_wr_q, rx_cap) : rx_wr_q;
    tx_lvl_d    = tx_lvl_q + LW'(tx_push_ok) - LW'(tx_pull_ok);
    rx_lvl_d    = rx_lvl_q + LW'(rx_push_ok) - LW'(rx_pull_ok);
    if (flush) begin
      tx_rd_d  = '0;
      tx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_wr_d  = '0;
      tx_lvl_d = '0;
      rx_lvl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      join_q   <= '0;
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      tx_lvl_q <= '0;
      rx_lvl_q <= '0;
      flags_q  <= '0;
    end else begin
      join_q   <= join_d;
      tx_rd_q  <= tx_rd_d;
      tx_wr_q  <= tx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_wr_q  <= rx_wr_d;
      tx_lvl_q <= tx_lvl_d;
      rx_lvl_q <= rx_lvl_d;
      flags_q  <= flags_d;
    end
  end

  // TX always starts at entry 0; RX starts at bank 1 when separate. Join modes give one
  // side zero capacity, so the two write ports never target the same entry.
  always_ff @(posedge clk) begin
    if (!reset && tx_push_ok) mem_q[tx_wr_q] <= tx_din_i;
    if (!reset && rx_push_ok) mem_q[rx_base + rx_wr_q] <= rx_din_i;
  end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Randomized and directed checks of pio_fifo_pair against a queue-based reference model.
module tb_pio_fifo_pair;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = $clog2(2*D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    join_s;
  logic          tx_push, tx_pull, rx_push, rx_pull;
  logic [W-1:0]  tx_din, rx_din, tx_dout, rx_dout;
  logic          tx_empty, tx_full, rx_empty, rx_full, tx_req, rx_req;
  logic [LW-1:0] tx_level, rx_level, tx_thresh, rx_thresh;
  logic [3:0]    flag_clr, flags;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [W-1:0] mtx[$];
  logic [W-1:0] mrx[$];
  logic [1:0]   mjoin;
  logic [3:0]   mflags;

  pio_fifo_pair #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .join_i(join_s),
    .tx_push_i(tx_push), .tx_din_i(tx_din), .tx_pull_i(tx_pull), .tx_dout_o(tx_dout),
    .rx_push_i(rx_push), .rx_din_i(rx_din), .rx_pull_i(rx_pull), .rx_dout_o(rx_dout),
    .tx_empty_o(tx_empty), .tx_full_o(tx_full), .rx_empty_o(rx_empty), .rx_full_o(rx_full),
    .tx_level_o(tx_level), .rx_level_o(rx_level),
    .tx_thresh_i(tx_thresh), .rx_thresh_i(rx_thresh),
    .tx_req_o(tx_req), .rx_req_o(rx_req),
    .flag_clr_i(flag_clr), .flags_o(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int txcap(input logic [1:0] j);
    case (j)
      2'b01:   return 2*D;
      2'b10:   return 0;
      default: return D;
    endcase
  endfunction

  function automatic int rxcap(input logic [1:0] j);
    case (j)
      2'b01:   return 0;
      2'b10:   return 2*D;
      default: return D;
    endcase
  endfunction

  task automatic idle();
    tx_push = 0; tx_pull = 0; rx_push = 0; rx_pull = 0;
    tx_din = '0; rx_din = '0; flag_clr = '0;
  endtask

  // Compare against the model before the edge, then advance the model with the same inputs.
  task automatic tick();
    int tc, rc, ts, rs;
    logic [3:0] set;
    @(negedge clk);
    tc = txcap(mjoin); rc = rxcap(mjoin);
    ts = mtx.size();   rs = mrx.size();
    check("tx_level", W'(tx_level), W'(ts));
    check("rx_level", W'(rx_level), W'(rs));
    check("tx_empty", W'(tx_empty), W'(ts == 0));
    check("tx_full",  W'(tx_full),  W'(ts == tc));
    check("rx_empty", W'(rx_empty), W'(rs == 0));
    check("rx_full",  W'(rx_full),  W'(rs == rc));
    check("tx_req",   W'(tx_req),   W'(ts < int'(tx_thresh)));
    check("rx_req",   W'(rx_req),   W'(rx_thresh != 0 && rs >= int'(rx_thresh)));
    check("flags",    W'(flags),    W'(mflags));
    if (ts > 0) check("tx_dout", tx_dout, mtx[0]);
    if (rs > 0) check("rx_dout", rx_dout, mrx[0]);
    if (reset) begin
      mtx.delete(); mrx.delete(); mjoin = 2'b00; mflags = '0;
    end else if (join_s != mjoin) begin
      mtx.delete(); mrx.delete(); mjoin = join_s;
      mflags = mflags & ~flag_clr;
    end else begin
      set = '0;
      set[0] = tc > 0 && tx_push && ts == tc;
      set[1] = tc > 0 && tx_pull && ts == 0;
      set[2] = rc > 0 && rx_push && rs == rc;
      set[3] = rc > 0 && rx_pull && rs == 0;
      mflags = (mflags & ~flag_clr) | set;
      if (tx_pull && ts > 0)  void'(mtx.pop_front());
      if (tx_push && ts < tc) mtx.push_back(tx_din);
      if (rx_pull && rs > 0)  void'(mrx.pop_front());
      if (rx_push && rs < rc) mrx.push_back(rx_din);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); join_s = 2'b00; reset = 1; tick(); reset = 0;
  endtask

  initial begin
    mjoin = 2'b00; mflags = '0;
    tx_thresh = LW'(2); rx_thresh = '0;
    do_reset();
    check("rst_tx_empty", W'(tx_empty), 1);
    check("rst_rx_empty", W'(rx_empty), 1);
    check("rst_tx_full",  W'(tx_full), 0);
    check("rst_rx_full",  W'(rx_full), 0);
    check("rst_flags",    W'(flags), 0);
    check("rst_tx_req",   W'(tx_req), 1);
    check("rst_rx_req",   W'(rx_req), 0);

    // Separate mode fill, overflow, ordered drain
    for (int i = 1; i <= 4; i++) begin tx_push = 1; tx_din = W'(i * 'h11); tick(); end
    tx_push = 0;
    check("sep_full", W'(tx_full), 1);
    check("sep_level", W'(tx_level), 4);
    tx_push = 1; tx_din = 'h55; tick(); tx_push = 0;
    check("sep_ovf_flag", W'(flags[0]), 1);
    check("sep_ovf_level", W'(tx_level), 4);
    for (int i = 1; i <= 4; i++) begin
      check("sep_order", tx_dout, W'(i * 'h11));
      tx_pull = 1; tick();
    end
    tx_pull = 0;

    // Join-TX: eight words through one FIFO, RX has zero capacity
    do_reset();
    join_s = 2'b01; tick(); tick();
    for (int i = 1; i <= 8; i++) begin tx_push = 1; tx_din = W'(i); tick(); end
    tx_push = 0;
    check("jtx_level", W'(tx_level), 8);
    check("jtx_full", W'(tx_full), 1);
    check("jtx_rx_full", W'(rx_full), 1);
    check("jtx_rx_empty", W'(rx_empty), 1);
    rx_push = 1; rx_din = 'hDEAD; tick(); rx_push = 0;
    check("jtx_rx_level", W'(rx_level), 0);
    check("jtx_no_rxflag", W'(flags[2]), 0);
    for (int i = 1; i <= 8; i++) begin
      check("jtx_order", tx_dout, W'(i));
      tx_pull = 1; tick();
    end
    tx_pull = 0;

    // Mode change flushes and swallows a concurrent push
    do_reset();
    for (int i = 0; i < 3; i++) begin tx_push = 1; tx_din = W'($urandom); tick(); end
    join_s = 2'b10; tx_din = 'h77; tick(); tx_push = 0;
    check("flush_tx_level", W'(tx_level), 0);
    check("flush_rx_level", W'(rx_level), 0);
    check("flush_flags", W'(flags), 0);

    // RX push+pull while empty, then while full
    do_reset();
    rx_push = 1; rx_pull = 1; rx_din = 'hA5; tick(); rx_pull = 0;
    check("rx_pp_level", W'(rx_level), 1);
    check("rx_pp_unf", W'(flags[3]), 1);
    check("rx_pp_dout", rx_dout, 'hA5);
    for (int i = 0; i < 3; i++) begin rx_din = W'(i + 1); tick(); end
    check("rx_full_pre", W'(rx_full), 1);
    rx_pull = 1; rx_din = 'hFF; tick(); rx_push = 0; rx_pull = 0;
    check("rx_fpp_level", W'(rx_level), 3);
    check("rx_fpp_ovf", W'(flags[2]), 1);
    check("rx_fpp_dout", rx_dout, 1);

    // Flag set beats clear in the same cycle
    do_reset();
    tx_pull = 1; flag_clr = 4'b0010; tick(); tx_pull = 0;
    check("stall_set", W'(flags[1]), 1);
    tick(); flag_clr = '0;
    check("stall_clr", W'(flags[1]), 0);

    // Random traffic in every mode, with a reset mid-stream
    for (int m = 0; m < 4; m++) begin
      idle(); join_s = 2'(m); tick();
      for (int c = 0; c < 40; c++) begin
        tx_push   = 1'($urandom_range(0, 1));
        tx_pull   = 1'($urandom_range(0, 2) == 0);
        rx_push   = 1'($urandom_range(0, 1));
        rx_pull   = 1'($urandom_range(0, 2) == 0);
        tx_din    = W'($urandom);
        rx_din    = W'($urandom);
        flag_clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        tx_thresh = LW'($urandom_range(0, 2*D));
        rx_thresh = LW'($urandom_range(0, 2*D));
        if (m == 1 && c == 20) begin
          reset = 1; tick(); reset = 0;
          check("mid_rst_tx_level", W'(tx_level), 0);
          check("mid_rst_rx_level", W'(rx_level), 0);
          check("mid_rst_flags", W'(flags), 0);
        end else begin
          tick();
        end
      end
    end
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
